// File: rtl/rgb_led_pwm.sv
// PWM driver for NUM_LEDS tri-colour LEDs with per-channel duty, per-LED blink
// and a global enable. Duty and blink mask are double-buffered to period boundaries.
module rgb_led_pwm #(
  parameter int NUM_LEDS      = 2,
  parameter int PWM_BITS      = 8,
  parameter int PRESCALE      = 16,
  parameter int BLINK_PERIODS = 64,
  parameter int ADDR_W        = 6
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_W-1:0]     wr_addr,
  input  logic [15:0]           wr_data,
  output logic [3*NUM_LEDS-1:0] rgb
);

  localparam int NCH   = 3 * NUM_LEDS;
  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int BLK_W = (BLINK_PERIODS > 1) ? $clog2(BLINK_PERIODS) : 1;

  localparam logic [PRE_W-1:0]    PRE_MAX   = PRE_W'(PRESCALE - 1);
  localparam logic [BLK_W-1:0]    BLK_MAX   = BLK_W'(BLINK_PERIODS - 1);
  localparam logic [PWM_BITS-1:0] CNT_MAX   = '1;
  localparam logic [ADDR_W-1:0]   CTRL_ADDR = ADDR_W'(NCH);

  typedef logic [PWM_BITS-1:0] duty_t;

  logic                ready_q;
  logic [PRE_W-1:0]    pre_q, pre_d;
  logic [PWM_BITS-1:0] cnt_q, cnt_d;
  logic [BLK_W-1:0]    blink_q, blink_d;
  logic                phase_q, phase_d;
  logic                enable_q, enable_d;
  logic [NUM_LEDS-1:0] mask_sh_q, mask_sh_d;
  logic [NUM_LEDS-1:0] mask_act_q, mask_act_d;
  duty_t               duty_sh_q  [NCH];
  duty_t               duty_sh_d  [NCH];
  duty_t               duty_act_q [NCH];
  duty_t               duty_act_d [NCH];
  logic [NCH-1:0]      rgb_q, rgb_d;

  logic tick;
  logic boundary;
  logic wr_fire;
  logic wr_data_unused;

  assign tick     = (pre_q == PRE_MAX);
  assign boundary = tick && (cnt_q == CNT_MAX);
  assign wr_fire  = wr_valid && ready_q;

  // Only the low PWM_BITS / NUM_LEDS+1 bits of a write carry information.
  assign wr_data_unused = ^wr_data;

  // NOTE: every signal gets a default at the top of always_comb so that no path
  // leaves it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    pre_d      = tick ? '0 : pre_q + 1'b1;
    cnt_d      = tick ? cnt_q + 1'b1 : cnt_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    enable_d   = enable_q;
    mask_sh_d  = mask_sh_q;
    mask_act_d = mask_act_q;
    duty_sh_d  = duty_sh_q;
    duty_act_d = duty_act_q;

    // The boundary reads the *_q shadows, so a write on the same edge is only
    // picked up at the following boundary.
    if (boundary) begin
      duty_act_d = duty_sh_q;
      mask_act_d = mask_sh_q;
      if (blink_q == BLK_MAX) begin
        blink_d = '0;
        phase_d = !phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
      end
    end

    if (wr_fire) begin
      for (int c = 0; c < NCH; c++) begin
        if (wr_addr == ADDR_W'(c)) duty_sh_d[c] = wr_data[PWM_BITS-1:0];
      end
      if (wr_addr == CTRL_ADDR) begin
        enable_d  = wr_data[0];
        mask_sh_d = wr_data[NUM_LEDS:1];
      end
    end

    for (int c = 0; c < NCH; c++) begin
      rgb_d[c] = enable_q && (cnt_q < duty_act_q[c]) && !(mask_act_q[c / 3] && phase_q);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of statement order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_q    <= 1'b0;
      pre_q      <= '0;
      cnt_q      <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b0;
      enable_q   <= 1'b0;
      mask_sh_q  <= '0;
      mask_act_q <= '0;
      // NOTE: the duty arrays are small flop banks, not RAM, so they can and
      // must be cleared by reset: LEDs restart dark until software rewrites them.
      duty_sh_q  <= '{default: '0};
      duty_act_q <= '{default: '0};
      rgb_q      <= '0;
    end else begin
      ready_q    <= 1'b1;
      pre_q      <= pre_d;
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      enable_q   <= enable_d;
      mask_sh_q  <= mask_sh_d;
      mask_act_q <= mask_act_d;
      duty_sh_q  <= duty_sh_d;
      duty_act_q <= duty_act_d;
      rgb_q      <= rgb_d;
    end
  end

  assign wr_ready = ready_q;
  assign rgb      = rgb_q;

endmodule

// File: tb/tb_rgb_led_pwm.sv
// Directed bench for rgb_led_pwm with NUM_LEDS=2, PWM_BITS=4, PRESCALE=2,
// BLINK_PERIODS=2 (32-cycle PWM period); high-time is counted per period window.
module tb_rgb_led_pwm;

  localparam int NCH = 6;
  localparam int PER = 32;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [5:0]  wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [5:0]  rgb;

  int checks = 0;
  int errors = 0;
  int cyc;
  int hi_cnt   [NCH];
  int first_hi [NCH];
  int start_cyc;

  rgb_led_pwm #(
    .NUM_LEDS(2), .PWM_BITS(4), .PRESCALE(2), .BLINK_PERIODS(2), .ADDR_W(6)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rgb     (rgb)
  );

  always #5 clk = ~clk;

  // Edges since reset release; the sample at the negedge after edge n shows the
  // output computed from the state of edge n-1, i.e. period position (n-1)%32.
  always @(posedge clk or negedge resetn) begin
    if (!resetn) cyc <= 0;
    else         cyc <= cyc + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic sync_phase(input int p);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((cyc % PER) != p && n <= 2 * PER);
    if ((cyc % PER) != p) begin
      checks++;
      errors++;
      $display("FAIL sync_timeout: got phase %0d expected %0d", cyc % PER, p);
    end
  endtask

  task automatic write(input logic [5:0] a, input logic [15:0] d);
    @(negedge clk);
    wr_addr  = a;
    wr_data  = d;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  // Counts high samples over one full period starting at cnt=0; optionally
  // issues one write asserted at sample index wr_idx (accepted on the next edge).
  task automatic measure(input int wr_idx, input logic [5:0] a, input logic [15:0] d);
    sync_phase(1);
    start_cyc = cyc;
    for (int c = 0; c < NCH; c++) begin
      hi_cnt[c]   = 0;
      first_hi[c] = -1;
    end
    for (int i = 0; i < PER; i++) begin
      if (i > 0) @(negedge clk);
      wr_valid = 1'b0;
      for (int c = 0; c < NCH; c++) begin
        if (rgb[c] === 1'b1) begin
          hi_cnt[c]++;
          if (first_hi[c] < 0) first_hi[c] = i;
        end
      end
      if (i == wr_idx) begin
        wr_addr  = a;
        wr_data  = d;
        wr_valid = 1'b1;
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic check_period(input string tag, input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int e5);
    int exp [NCH];
    exp = '{e0, e1, e2, e3, e4, e5};
    for (int c = 0; c < NCH; c++) check($sformatf("%s_ch%0d", tag, c), hi_cnt[c], exp[c]);
  endtask

  initial begin
    int j;
    int led1;

    // Reset held for 5 cycles.
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_rgb", rgb, 0);
    check("rst_ready", wr_ready, 0);
    resetn = 1'b1;
    #1;
    check("rel_ready_before_edge", wr_ready, 0);
    @(negedge clk);
    check("rel_ready_after_edge", wr_ready, 1);
    measure(-1, '0, '0);
    check_period("idle", 0, 0, 0, 0, 0, 0);

    // Basic duty: 4 steps of 2 cycles -> 8 high cycles from cnt=0.
    write(6'd0, 16'd4);
    write(6'd6, 16'd1);
    measure(-1, '0, '0);
    check_period("basic", 8, 0, 0, 0, 0, 0);
    check("basic_first_hi", first_hi[0], 0);

    // Extremes: duty 0 never high, duty 15 high 30 of 32.
    write(6'd1, 16'd0);
    write(6'd2, 16'd15);
    measure(-1, '0, '0);
    check_period("extreme", 8, 0, 30, 0, 0, 0);
    check("extreme_first_hi", first_hi[2], 0);

    // Double buffering: mid-period write waits for the boundary; a write on
    // the boundary edge itself waits one more period.
    measure(10, 6'd0, 16'd8);
    check("dbuf_mid_same", hi_cnt[0], 8);
    measure(30, 6'd0, 16'd2);
    check("dbuf_mid_next", hi_cnt[0], 16);
    measure(-1, '0, '0);
    check("dbuf_bnd_same", hi_cnt[0], 16);
    measure(-1, '0, '0);
    check("dbuf_bnd_next", hi_cnt[0], 4);

    // Blink LED1: phase toggles every second boundary since reset.
    for (int c = 0; c < NCH; c++) write(6'(c), 16'd8);
    write(6'd6, 16'b101);
    for (int p = 0; p < 4; p++) begin
      measure(-1, '0, '0);
      j    = (start_cyc - 1) / PER;
      led1 = (((j / 2) % 2) == 1) ? 0 : 16;
      check_period($sformatf("blink%0d", p), 16, 16, 16, led1, led1, led1);
    end

    // Disable mid-pulse: still high one sample after acceptance, dark after two.
    sync_phase(5);
    wr_addr  = 6'd6;
    wr_data  = 16'd0;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    check("dis_accept_plus1", rgb[0], 1);
    @(negedge clk);
    check("dis_accept_plus2", rgb, 0);
    measure(-1, '0, '0);
    check_period("disabled", 0, 0, 0, 0, 0, 0);

    // Re-enable past the pulse: stays dark until cnt wraps, then in phase.
    sync_phase(21);
    wr_addr  = 6'd6;
    wr_data  = 16'd1;
    wr_valid = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0;
    @(negedge clk);
    check("reen_mid_dark", rgb, 0);
    measure(-1, '0, '0);
    check_period("reen", 16, 16, 16, 16, 16, 16);
    check("reen_first_hi", first_hi[0], 0);

    // Asynchronous reset mid-pulse.
    sync_phase(5);
    check("pre_rst_pulse", rgb[0], 1);
    resetn = 1'b0;
    #1;
    check("mid_rst_rgb", rgb, 0);
    check("mid_rst_ready", wr_ready, 0);
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    write(6'd6, 16'd1);
    measure(-1, '0, '0);
    check_period("post_rst", 0, 0, 0, 0, 0, 0);
    write(6'd3, 16'd6);
    measure(-1, '0, '0);
    check_period("post_rst_rewrite", 0, 0, 0, 12, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
